// File: rtl/cq_reader_pkg.sv
// Shared constants and FSM state encoding for the completion-queue reader.
package cq_reader_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH      = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2
  } state_e;

endpackage

// File: rtl/cq_reader_ptr_reg.sv
// Loadable pointer register with asynchronous active-high reset; holds rd_ptr.
module cq_ptr_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // pointer storage: clears on reset, loads when requested
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/cq_reader.sv
// Completion-queue reader: pulls entries from storage one at a time and presents
// them on a registered valid/ready output, tracking occupancy against the writer.
module cq_reader
  import cq_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W:0]   wr_ptr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ptr_err
);

  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              ptr_err_q, ptr_err_d;
  logic              ptr_load_s;
  logic [ADDR_W:0]   ptr_d;
  logic [ADDR_W:0]   rd_ptr_s;
  logic [ADDR_W:0]   count_s;
  logic              empty_s;
  logic              rd_en_s;

  cq_ptr_reg #(.W(ADDR_W + 1)) u_ptr (
    .clk    (clk),
    .reset  (reset),
    .load_i (ptr_load_s),
    .d_i    (ptr_d),
    .q_o    (rd_ptr_s)
  );

  // occupancy from the live registered pointers of both sides
  always_comb begin
    count_s = wr_ptr - rd_ptr_s;
    empty_s = (rd_ptr_s == wr_ptr);
  end

  // next-state, read strobe and output-register updates; flush overrides everything
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_en_s     = 1'b0;
    ptr_load_s  = 1'b0;
    ptr_d       = rd_ptr_s + ONE_L;
    if (flush) begin
      ptr_d       = wr_ptr;
      ptr_load_s  = 1'b1;
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_d = 1'b0;
          if (!empty_s) begin
            rd_en_s    = 1'b1;
            ptr_load_s = 1'b1;
            state_d    = ST_READ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_READ: begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          state_d     = ST_VALID;
        end
        ST_VALID: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (!empty_s) begin
              rd_en_s    = 1'b1;
              ptr_load_s = 1'b1;
              state_d    = ST_READ;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  // sticky overflow flag, cleared only by flush or reset
  always_comb begin
    if (flush) begin
      ptr_err_d = 1'b0;
    end else begin
      ptr_err_d = ptr_err_q | (count_s > DEPTH_L);
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ptr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ptr_err_q   <= ptr_err_d;
    end
  end

  assign rd_en     = rd_en_s;
  assign rd_ptr    = rd_ptr_s;
  assign rd_addr   = rd_ptr_s[ADDR_W-1:0];
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign empty     = empty_s;
  assign count     = count_s;
  assign ptr_err   = ptr_err_q;

endmodule

// File: doc/cq_reader.md
CQ_READER -- requirements
Module: cq_reader

Interface
REQ-001 Parameter DATA_W, default 16, entry width in bits.
REQ-002 Parameter ADDR_W, default 4, queue address width; DEPTH = 2^ADDR_W (16).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_ptr  input  ADDR_W+1  writer pointer; MSB is the wrap bit; registered in the clk domain by the writer.
REQ-006 rd_data  input  DATA_W  storage read data, valid exactly one cycle after rd_en.
REQ-007 out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 flush  input  1  synchronous discard of all queued entries.
REQ-009 rd_en  output  1  storage read strobe (combinational).
REQ-010 rd_addr  output  ADDR_W  storage read address, equal to rd_ptr[ADDR_W-1:0].
REQ-011 rd_ptr  output  ADDR_W+1  reader pointer with wrap bit, returned to the writer.
REQ-012 out_data  output  DATA_W  dequeued entry (registered).
REQ-013 out_valid  output  1  out_data holds an entry (registered).
REQ-014 empty  output  1  rd_ptr == wr_ptr (combinational).
REQ-015 count  output  ADDR_W+1  wr_ptr - rd_ptr modulo 2^(ADDR_W+1).
REQ-016 ptr_err  output  1  sticky flag set when count > DEPTH.

Function
REQ-017 The FSM SHALL have three states: IDLE, READ, VALID.
REQ-018 IDLE: out_valid=0; when !empty, assert rd_en, increment rd_ptr, and go to READ.
REQ-019 READ: capture rd_data into out_data, set out_valid=1, and go to VALID; rd_en=0.
REQ-020 VALID: hold out_data and out_valid=1 until out_ready=1.
REQ-021 VALID with out_ready=1 and !empty: assert rd_en, increment rd_ptr, and go to READ; out_valid is 0 in the next cycle.
REQ-022 VALID with out_ready=1 and empty: go to IDLE.
REQ-023 rd_en SHALL be asserted only in the cycle rd_ptr increments; it is never asserted when empty=1.
REQ-024 Latency is 2 cycles from empty deasserting in IDLE to out_valid=1; peak throughput is 1 entry per 2 cycles.
REQ-025 rd_ptr increments modulo 2^(ADDR_W+1); rd_addr wraps 15 -> 0 while the wrap bit toggles.
REQ-026 empty and count SHALL be computed from the current registered rd_ptr and the current wr_ptr.
REQ-027 A wr_ptr change in the same cycle as a read SHALL be visible to empty and count the next cycle, without loss.
REQ-028 ptr_err SHALL be set whenever count > 16; it clears only on reset or flush.
REQ-029 flush has priority over all else: rd_ptr <= wr_ptr, out_valid <= 0, state <= IDLE, ptr_err <= 0, and rd_en=0 in that cycle.
REQ-030 out_data SHALL retain its last value when out_valid=0.

Reset
REQ-031 Reset asserted: rd_ptr=0, state=IDLE, out_valid=0, out_data=0, ptr_err=0, all applied immediately, without waiting for clk.
REQ-032 Reset mid-READ SHALL drop the in-flight entry; the first read after release uses address 0.
REQ-033 Reset deassertion SHALL take effect at the next clk edge; no read is issued in the release cycle unless !empty.

Structure
REQ-034 The shared package SHALL hold the DATA_W/ADDR_W defaults, the DEPTH constant, and the state encoding (IDLE=0, READ=1, VALID=2).
REQ-035 The rd_ptr register SHALL be a sub-module cq_ptr_reg: an (ADDR_W+1)-bit load register with async reset; all other logic is inline.

Verification
REQ-036 Reset, then wr_ptr=0 for 10 cycles -> empty=1, count=0, rd_en never asserted, out_valid=0.
REQ-037 wr_ptr 0->3 with storage holding A0,A1,A2 and out_ready=1 -> out_data A0,A1,A2 on out_valid in cycles 2, 4, 6; rd_ptr ends at 3; empty=1.
REQ-038 out_ready=0 for 5 cycles with one entry out -> out_data stable, out_valid=1, rd_ptr unchanged, no rd_en.
REQ-039 rd_ptr=14, wr_ptr=18 (wrapped) -> rd_addr sequence 14, 15, 0, 1; rd_ptr goes 15, 16, 17, 18; count goes 4 -> 0.
REQ-040 wr_ptr=17 with rd_ptr=0 -> ptr_err=1 and stays 1 after wr_ptr returns to 5; flush -> ptr_err=0, rd_ptr=5, out_valid=0.
REQ-041 Reset asserted between clk edges during READ -> out_valid=0 and rd_ptr=0 immediately; the next read after release is at rd_addr=0.
